// File: rtl/serial_pkg.sv
// Shared types and ASCII constants for the serial hex formatter.
// SERIAL_HEX_PREFIX_EN adds the PFX0/PFX1 states used to print "0x".
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef SERIAL_HEX_PREFIX_EN
    ST_PFX0,
    ST_PFX1,
`endif
    ST_DIGIT,
    ST_CR,
    ST_LF
  } hexfmt_state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_X   = 8'h78;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational converter from one 4-bit nibble to its uppercase ASCII hex digit.
module hex_nibble_ascii
  import serial_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // 0..9 map onto '0'..'9', A..F onto 'A'..'F'
  always_comb begin
    ascii = ASCII_0;
    if (nib < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nib};
    end else begin
      ascii = ASCII_A + {4'h0, nib - 4'd10};
    end
  end

endmodule

// File: rtl/serial_hex_fmt.sv
// Prints a parallel word as uppercase ASCII hex followed by CR LF, one byte at
// a time into serial_tx. Define SERIAL_HEX_PREFIX_EN to start each line with "0x".
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a word, data_ready high
// ST_PFX0  | presenting '0' of the prefix (prefix builds only)
// ST_PFX1  | presenting 'x' of the prefix (prefix builds only)
// ST_DIGIT | presenting the nibble selected by idx, MSB first
// ST_CR    | presenting carriage return
// ST_LF    | presenting line feed, then back to idle
module serial_hex_fmt
  import serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk12,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [7:0]       sbyte,
  output logic             sbyte_rdy,
  input  logic             ack,
  output logic             busy
);

  localparam int NDIG = WIDTH / 4;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

  hexfmt_state_t    state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [3:0]       nib;
  logic [7:0]       digit_ascii;

  // state, word and digit index registers
  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // next-state logic: accept a word in idle, otherwise advance on ack
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          word_d  = data;
          idx_d   = IDX_TOP;
`ifdef SERIAL_HEX_PREFIX_EN
          state_d = ST_PFX0;
`else
          state_d = ST_DIGIT;
`endif
        end
      end
`ifdef SERIAL_HEX_PREFIX_EN
      ST_PFX0: if (ack) state_d = ST_PFX1;
      ST_PFX1: if (ack) state_d = ST_DIGIT;
`endif
      ST_DIGIT: begin
        if (ack) begin
          if (idx_q == '0) begin
            state_d = ST_CR;
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end
      end
      ST_CR:   if (ack) state_d = ST_LF;
      ST_LF:   if (ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // select the nibble addressed by the registered digit index
  always_comb begin
    nib = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IDXW'(i)) nib = word_q[i*4 +: 4];
    end
  end

  hex_nibble_ascii u_nib (
    .nib   (nib),
    .ascii (digit_ascii)
  );

  // outputs decode from registered state only, so ack never loops back into sbyte
  always_comb begin
    sbyte      = ASCII_NUL;
    sbyte_rdy  = 1'b1;
    data_ready = 1'b0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        sbyte_rdy  = 1'b0;
        data_ready = 1'b1;
        busy       = 1'b0;
      end
`ifdef SERIAL_HEX_PREFIX_EN
      ST_PFX0:  sbyte = ASCII_0;
      ST_PFX1:  sbyte = ASCII_X;
`endif
      ST_DIGIT: sbyte = digit_ascii;
      ST_CR:    sbyte = ASCII_CR;
      ST_LF:    sbyte = ASCII_LF;
      default: begin
        sbyte_rdy  = 1'b0;
        data_ready = 1'b1;
        busy       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_hex_fmt.sv
// Directed bench for serial_hex_fmt: a WIDTH=16 instance paced by an
// 11-cycle serial_tx-style ack, plus a WIDTH=4 instance for the single-digit case.
// Expectations follow SERIAL_HEX_PREFIX_EN when the build defines it.
module tb_serial_hex_fmt;

  logic        clk12 = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  sbyte;
  logic        sbyte_rdy;
  logic        ack;
  logic        busy;

  logic [3:0]  data4;
  logic        dv4;
  logic        dr4;
  logic [7:0]  sb4;
  logic        sr4;
  logic        ack4;
  logic        busy4;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_b[8];
  int         exp_n;
  int         pfx_n;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [31:0] digits;
    int          hold_first;
  } vec_t;

  vec_t vecs[5];

  always #5 clk12 = ~clk12;

  serial_hex_fmt #(.WIDTH(16)) u_dut (
    .clk12      (clk12),
    .rst_n      (rst_n),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sbyte      (sbyte),
    .sbyte_rdy  (sbyte_rdy),
    .ack        (ack),
    .busy       (busy)
  );

  serial_hex_fmt #(.WIDTH(4)) u_dut4 (
    .clk12      (clk12),
    .rst_n      (rst_n),
    .data       (data4),
    .data_valid (dv4),
    .data_ready (dr4),
    .sbyte      (sb4),
    .sbyte_rdy  (sr4),
    .ack        (ack4),
    .busy       (busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  // expected byte list for one 16-bit line: optional "0x", four digits, CR LF
  task automatic build_exp(input logic [31:0] digits);
    exp_n = 0;
`ifdef SERIAL_HEX_PREFIX_EN
    exp_b[0] = 8'h30;
    exp_b[1] = 8'h78;
    exp_n = 2;
`endif
    for (int k = 0; k < 4; k++) begin
      exp_b[exp_n] = digits[31 - 8*k -: 8];
      exp_n++;
    end
    exp_b[exp_n] = 8'h0D;
    exp_b[exp_n + 1] = 8'h0A;
    exp_n += 2;
  endtask

  // called at a negedge where the byte must already be presented; holds it
  // for 'hold' cycles and acks in the last one, returning one cycle later
  task automatic take_byte(input logic [7:0] expv, input int hold, input string name);
    logic stable;
    stable = 1'b1;
    chk({name, " rdy"}, 32'(sbyte_rdy), 32'h1);
    chk({name, " byte"}, 32'(sbyte), 32'(expv));
    for (int c = 0; c < hold; c++) begin
      if (sbyte !== expv || sbyte_rdy !== 1'b1) stable = 1'b0;
      if (c == hold - 1) ack = 1'b1;
      @(negedge clk12);
    end
    ack = 1'b0;
    chk({name, " stable"}, 32'(stable), 32'h1);
  endtask

  task automatic run_line(input logic [15:0] d, input logic [31:0] digits,
                          input int hold_first, input string name);
    data       = d;
    data_valid = 1'b1;
    @(negedge clk12);
    data_valid = 1'b0;
    build_exp(digits);
    for (int b = 0; b < exp_n; b++) begin
      take_byte(exp_b[b], (b == 0) ? hold_first : 11, name);
    end
    chk({name, " busy after LF"}, 32'(busy), 32'h0);
    chk({name, " ready after LF"}, 32'(data_ready), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SERIAL_HEX_PREFIX_EN
    pfx_n = 2;
`else
    pfx_n = 0;
`endif
    vecs[0] = '{"basic",    16'h1A2F, 32'h3141_3246, 11};
    vecs[1] = '{"prefix",   16'h00B7, 32'h3030_4237, 11};
    vecs[2] = '{"zeros",    16'h0000, 32'h3030_3030, 11};
    vecs[3] = '{"ones",     16'hFFFF, 32'h4646_4646, 11};
    vecs[4] = '{"backpres", 16'h1A2F, 32'h3141_3246, 21};

    rst_n = 1'b0; data = '0; data_valid = 1'b0; ack = 1'b0;
    data4 = '0; dv4 = 1'b0; ack4 = 1'b0;
    repeat (3) @(negedge clk12);
    chk("reset ready", 32'(data_ready), 32'h1);
    chk("reset rdy",   32'(sbyte_rdy),  32'h0);
    chk("reset sbyte", 32'(sbyte),      32'h0);
    chk("reset busy",  32'(busy),       32'h0);
    chk("reset4 rdy",  32'(sr4),        32'h0);
    rst_n = 1'b1;
    @(negedge clk12);

    for (int v = 0; v < 5; v++) begin
      run_line(vecs[v].data, vecs[v].digits, vecs[v].hold_first, vecs[v].name);
      @(negedge clk12);
    end

    // busy ignore and back-to-back capture
    data       = 16'h1234;
    data_valid = 1'b1;
    @(negedge clk12);
    data = 16'h5678;
    build_exp(32'h3132_3334);
    for (int b = 0; b < exp_n; b++) take_byte(exp_b[b], 11, "b2b first");
    chk("b2b idle ready", 32'(data_ready), 32'h1);
    chk("b2b idle busy",  32'(busy),       32'h0);
    @(negedge clk12);
    data_valid = 1'b0;
    chk("b2b capture busy", 32'(busy), 32'h1);
    build_exp(32'h3536_3738);
    for (int b = 0; b < exp_n; b++) take_byte(exp_b[b], 11, "b2b second");
    @(negedge clk12);

    // reset during the third digit
    data       = 16'h1A2F;
    data_valid = 1'b1;
    @(negedge clk12);
    data_valid = 1'b0;
    build_exp(32'h3141_3246);
    for (int b = 0; b < pfx_n + 2; b++) take_byte(exp_b[b], 11, "pre-reset");
    chk("third digit", 32'(sbyte), 32'h32);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst rdy",   32'(sbyte_rdy),  32'h0);
    chk("async rst busy",  32'(busy),       32'h0);
    chk("async rst ready", 32'(data_ready), 32'h1);
    #1 rst_n = 1'b1;
    @(negedge clk12);
    chk("post rst rdy", 32'(sbyte_rdy), 32'h0);
    run_line(16'hABCD, 32'h4142_4344, 11, "after reset");
    @(negedge clk12);

    // WIDTH=4 single digit
    data4 = 4'h9;
    dv4   = 1'b1;
    @(negedge clk12);
    dv4 = 1'b0;
    exp_n = 0;
`ifdef SERIAL_HEX_PREFIX_EN
    exp_b[0] = 8'h30; exp_b[1] = 8'h78; exp_n = 2;
`endif
    exp_b[exp_n] = 8'h39; exp_b[exp_n + 1] = 8'h0D; exp_b[exp_n + 2] = 8'h0A;
    exp_n += 3;
    for (int b = 0; b < exp_n; b++) begin
      chk("w4 rdy",  32'(sr4), 32'h1);
      chk("w4 byte", 32'(sb4), 32'(exp_b[b]));
      repeat (2) @(negedge clk12);
      ack4 = 1'b1;
      @(negedge clk12);
      ack4 = 1'b0;
    end
    chk("w4 busy after LF", 32'(busy4), 32'h0);
    chk("w4 ready after LF", 32'(dr4), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
